sram_mem_ctrl: RTL

//  Data-memory controller between the MEM stage and an external 16-bit asynchronous SRAM.

---
 rtl/sram_mem_ctrl_pkg.sv | 31 +++
 rtl/sram_wait_counter.sv | 43 ++++
 rtl/sram_mem_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sram_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_mem_ctrl_pkg
//   Shared definitions for the data-memory SRAM controller: FSM state
//   encoding, default memory map / timing constants and the byte-address to
//   halfword-address helper.
// ----------------------------------------------------------------------------
package sram_mem_ctrl_pkg;

    // Controller sequencing: idle, low-half access, high-half access,
    // one-cycle completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 5;
    localparam int          DEF_SRAM_AW     = 18;
    localparam int          SRAM_DW         = 16;

    // Halfword address of the low half of the 32-bit word holding byte_addr:
    // ((byte_addr - base) >> 2) << 1. Byte-lane bits are dropped and the
    // result wraps; the caller truncates to the SRAM address width.
    function automatic logic [31:0] lo_half_addr(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
        return ((byte_addr - base) >> 1) & ~32'd1;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
//   Counts the clocks of one 16-bit SRAM access, 0..WAIT_CYCLES-1.
//   Ports:
//     clk    in  system clock, rising edge
//     rst    in  synchronous reset, active-low
//     clear  in  force the count to 0 on the next edge (has priority)
//     enable in  advance the count on the next edge
//     last   out count is at WAIT_CYCLES-1
// ----------------------------------------------------------------------------
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int              CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others; reset is synchronous, so it sits inside
    // the clocked branch with no edge on rst in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/sram_mem_ctrl.sv
// ----------------------------------------------------------------------------
// sram_mem_ctrl
//   Data-memory controller between the MEM stage and a 16-bit asynchronous
//   SRAM. Each 32-bit load/store becomes two fixed-length halfword accesses,
//   low half first. ready is low while a request is in flight and is used
//   upstream as the pipeline freeze.
//   Ports:
//     clk, rst           clock (rising edge), synchronous active-low reset
//     rd_en, wr_en       load / store request (store wins if both)
//     address            byte address; bits [1:0] ignored
//     write_data         store data
//     read_data          registered load result, updated only by loads
//     ready              1 when idle with no request, or in the completion cycle
//     sram_addr          halfword address (registered)
//     sram_dq_in         data from SRAM
//     sram_dq_out        data to SRAM (registered)
//     sram_dq_oe         1 = drive sram_dq_out onto the bus
//     sram_ce_n/oe_n/we_n  active-low SRAM strobes, decoded from registers only
// ----------------------------------------------------------------------------
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_t             state, state_next;
    logic               op_wr;        // latched operation: 1 = store
    logic [SRAM_DW-1:0] wdata_hi_q;   // high store half, driven during HI
    logic               req;
    logic               in_phase;
    logic               cnt_last;

    assign req      = rd_en | wr_en;
    assign in_phase = (state == LO) || (state == HI);

    // Counter idles at 0 outside the access phases and rolls back to 0 at the
    // end of each phase, so LO and HI both start from a fresh count.
    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_phase || cnt_last),
        .enable (in_phase),
        .last   (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_next = LO;
            end
            LO:      if (cnt_last) state_next = HI;
            HI:      if (cnt_last) state_next = DONE;
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and SRAM address/data registers. Inputs are sampled only
    // in IDLE; sram_addr holds {word,0} through LO and is bumped to {word,1}
    // on the LO->HI edge, so no separate word register is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_wr       <= 1'b0;
            wdata_hi_q  <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_wr     <= wr_en;
                        sram_addr <= SRAM_AW'(lo_half_addr(address, BASE_ADDR));
                        if (wr_en) begin
                            sram_dq_out <= write_data[15:0];
                            wdata_hi_q  <= write_data[31:16];
                        end
                    end
                end
                LO: begin
                    if (cnt_last) begin
                        sram_addr <= sram_addr | SRAM_AW'(1);
                        if (op_wr) sram_dq_out      <= wdata_hi_q;
                        else       read_data[15:0]  <= sram_dq_in;
                    end
                end
                HI: begin
                    if (cnt_last && !op_wr) read_data[31:16] <= sram_dq_in;
                end
                default: ;
            endcase
        end
    end

    // Strobes depend only on registered state, op and counter. we_n rises on
    // the last cycle of each phase while data and address are still driven,
    // giving hold time past the write-ending edge.
    assign sram_ce_n  = ~in_phase;
    assign sram_oe_n  = ~(in_phase && !op_wr);
    assign sram_dq_oe = in_phase && op_wr;
    assign sram_we_n  = ~(in_phase && op_wr && !cnt_last);

endmodule
